// File: rtl/fp_divider_if.sv
// ============================================================================
//  Module      : fp_divider_if
//  Description : Request/result bundle for the iterative FP divider.
//                master : requester (drives start, a, b)
//                slave  : divider   (drives busy, done, quotient, flags)
//  Ports       : start, a, b            request side
//                busy, done, quotient,  result side
//                overflow, div_by_zero
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fp_divider_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
);
  localparam int WIDTH = 1 + EXP_W + MANT_W;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, quotient, overflow, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, overflow, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/fp_divider.sv
// ============================================================================
//  Module      : fp_divider
//  Description : Iterative single-precision divider, quotient = a / b.
//                Restoring division producing one quotient bit per clock,
//                implicit-1 mantissas, round-half-up, saturation to +/-inf on
//                exponent overflow and flush to zero on underflow.
//  Ports       : clk  rising-edge clock
//                rst  synchronous active-high reset
//                bus  fp_divider_if.slave (start/a/b in, busy/done/quotient/
//                     overflow/div_by_zero out)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_divider #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  wire logic clk,
  input  wire logic rst,
  fp_divider_if.slave bus
);

  localparam int WIDTH = 1 + EXP_W + MANT_W;
  localparam int BIAS  = 2**(EXP_W-1) - 1;
  localparam int EMAX  = 2**EXP_W - 1;
  localparam int ITER  = MANT_W + 3;
  localparam int E_W   = EXP_W + 2;        // signed working exponent
  localparam int R_W   = MANT_W + 2;       // remainder / divisor width
  localparam int CNT_W = $clog2(ITER);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_UNPACK = 2'd1;
  localparam logic [1:0] S_DIVIDE = 2'd2;
  localparam logic [1:0] S_NORM   = 2'd3;

  logic [1:0]              state;
  logic [WIDTH-1:0]        a_reg;
  logic [WIDTH-1:0]        b_reg;
  logic                    sign;
  logic signed [E_W-1:0]   exp_w;
  logic [R_W-1:0]          rem;
  logic [R_W-1:0]          dvs;
  logic [ITER-1:0]         q;
  logic [CNT_W-1:0]        cnt;

  logic                    busy_r;
  logic                    done_r;
  logic [WIDTH-1:0]        quot_r;
  logic                    ovf_r;
  logic                    dbz_r;

  // Zero detection ignores the sign bit.
  logic a_zero;
  logic b_zero;
  assign a_zero = (a_reg[WIDTH-2:0] == '0);
  assign b_zero = (b_reg[WIDTH-2:0] == '0);

  // One restoring step. The remainder stays below the divisor after the
  // conditional subtract, so the left shift never loses a set bit.
  logic           rem_ge;
  logic [R_W-1:0] rem_sub;
  assign rem_ge  = (rem >= dvs);
  assign rem_sub = rem_ge ? (rem - dvs) : rem;

  // Normalise on the integer bit, round half-up on the first dropped bit.
  logic [MANT_W:0]       m_sum;
  logic [MANT_W-1:0]     m_fin;
  logic signed [E_W-1:0] e_fin;
  always_comb begin
    m_sum = '0;
    e_fin = exp_w;
    if (q[ITER-1]) begin
      m_sum = {1'b0, q[ITER-2:2]} + {{MANT_W{1'b0}}, q[1]};
    end else begin
      m_sum = {1'b0, q[ITER-3:1]} + {{MANT_W{1'b0}}, q[0]};
      e_fin = exp_w - E_W'(1);
    end
    // A rounding carry means the mantissa wrapped to 1.0 of the next binade.
    if (m_sum[MANT_W]) begin
      e_fin = e_fin + E_W'(1);
    end
    m_fin = m_sum[MANT_W] ? '0 : m_sum[MANT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      quot_r <= '0;
      ovf_r  <= 1'b0;
      dbz_r  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      sign   <= 1'b0;
      exp_w  <= '0;
      rem    <= '0;
      dvs    <= '0;
      q      <= '0;
      cnt    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_reg  <= bus.a;
            b_reg  <= bus.b;
            busy_r <= 1'b1;
            state  <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign  <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
          exp_w <= $signed({2'b00, a_reg[WIDTH-2:MANT_W]})
                 - $signed({2'b00, b_reg[WIDTH-2:MANT_W]})
                 + $signed(E_W'(BIAS));
          rem   <= {1'b0, 1'b1, a_reg[MANT_W-1:0]};
          dvs   <= {1'b0, 1'b1, b_reg[MANT_W-1:0]};
          q     <= '0;
          cnt   <= '0;
          state <= (a_zero || b_zero) ? S_NORM : S_DIVIDE;
        end
        S_DIVIDE: begin
          rem <= rem_sub << 1;
          q   <= {q[ITER-2:0], rem_ge};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER-1)) begin
            state <= S_NORM;
          end
        end
        S_NORM: begin
          if (b_zero) begin
            quot_r <= {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            dbz_r  <= 1'b1;
            ovf_r  <= 1'b0;
          end else if (a_zero) begin
            quot_r <= '0;
            dbz_r  <= 1'b0;
            ovf_r  <= 1'b0;
          end else if (e_fin >= $signed(E_W'(EMAX))) begin
            quot_r <= {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            dbz_r  <= 1'b0;
            ovf_r  <= 1'b1;
          end else if (e_fin <= $signed(E_W'(0))) begin
            quot_r <= '0;
            dbz_r  <= 1'b0;
            ovf_r  <= 1'b0;
          end else begin
            quot_r <= {sign, e_fin[EXP_W-1:0], m_fin};
            dbz_r  <= 1'b0;
            ovf_r  <= 1'b0;
          end
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.overflow    = ovf_r;
  assign bus.div_by_zero = dbz_r;

endmodule

`default_nettype wire

// File: tb/tb_fp_divider.sv
// ============================================================================
//  Module      : tb_fp_divider
//  Description : Self-checking bench for fp_divider. Expected results are
//                queued when a request is issued and compared when done fires.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_divider;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   acc_cyc;
  int   busy_cnt;

  typedef struct {
    logic [31:0] q;
    logic        ovf;
    logic        dbz;
  } exp_t;

  exp_t sb[$];

  fp_divider_if bus ();

  fp_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Result monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL unexpected_done: observed done=1 expected no result pending");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient",    bus.quotient,            e.q);
        check("overflow",    {31'd0, bus.overflow},    {31'd0, e.ovf});
        check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
      end
    end
  end

  // Called at #1 after an edge; presents the request for exactly one edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic eo, input logic ez);
    exp_t e;
    e.q = eq; e.ovf = eo; e.dbz = ez;
    sb.push_back(e);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    acc_cyc   = cyc;
    busy_cnt  = (bus.busy === 1'b1) ? 1 : 0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) busy_cnt++;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $error("FAIL %s_timeout: observed no done expected done within 100 cycles", tag);
    end else begin
      check({tag, "_latency"}, cyc - acc_cyc, exp_lat);
      if (exp_busy >= 0) check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    end
  endtask

  initial begin
    int dcount;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",     {31'd0, bus.busy},        32'd0);
    check("rst_done",     {31'd0, bus.done},        32'd0);
    check("rst_quotient", bus.quotient,             32'h0);
    check("rst_overflow", {31'd0, bus.overflow},    32'd0);
    check("rst_dbz",      {31'd0, bus.div_by_zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 6.0 / 2.0
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    wait_done("six_by_two", 28, 28);

    // 1 / 3 : integer bit clear, rounds up
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0);
    wait_done("one_third", 28, 28);

    // -7.5 / 2.5
    issue(32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0, 1'b0);
    wait_done("neg_div", 28, 28);

    // 1 / -0 : divide by zero, signed infinity, short path
    issue(32'h3F800000, 32'h80000000, 32'hFF800000, 1'b0, 1'b1);
    wait_done("div_zero", 2, 2);

    // 0 / 2
    issue(32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
    wait_done("zero_num", 2, 2);

    // 0 / 0 : divisor test wins
    issue(32'h00000000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1);
    wait_done("zero_zero", 2, 2);

    // overflow
    issue(32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1, 1'b0);
    wait_done("overflow", 28, 28);

    // reset mid-divide: outputs clear, no result
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb.pop_back());
    check("abort_busy",     {31'd0, bus.busy},        32'd0);
    check("abort_done",     {31'd0, bus.done},        32'd0);
    check("abort_quotient", bus.quotient,             32'h0);
    check("abort_overflow", {31'd0, bus.overflow},    32'd0);
    check("abort_dbz",      {31'd0, bus.div_by_zero}, 32'd0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dcount++;
    end
    check("abort_no_done", dcount, 0);

    // underflow flushes to zero
    issue(32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
    wait_done("underflow", 28, 28);

    // start mid-divide is ignored
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    bus.a = 32'h3F800000;
    bus.b = 32'h40400000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("ignore_start", 28, -1);

    // back-to-back: start during the done cycle
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0);
    wait_done("b2b_second", 28, 28);

    @(posedge clk);
    #1;
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dcount++;
    end
    check("no_extra_done", dcount, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
